// File: rtl/brg_ctrl.sv
// brg_ctrl: baud-rate controller for the UART.
// Divisor writes arrive as two bytes (low, then high), are staged, and the new
// 16-bit divisor is applied only at a baud-period boundary so uart_clk never
// produces a runt cycle. Period P = 16 + div_active sys_clk cycles.
// Optional feature macro: BRG_CTRL_DONE_EN adds the cfg_done commit pulse.

module brg_ctrl #(
    parameter logic [15:0] RST_DIV = 16'h02F0
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        en,
    input  logic        wr_en,
    input  logic        wr_addr,
    input  logic [7:0]  wr_data,
    output logic [15:0] div_active,
    output logic        cfg_busy,
    output logic        uart_clk,
    output logic        baud_tick
`ifdef BRG_CTRL_DONE_EN
    ,
    output logic        cfg_done
`endif
);

    // IDLE: generator off; RUN: counting, nothing staged; PEND: counting with
    // a committed divisor waiting for the period wrap.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_nxt;

    logic [16:0] cnt_q;
    logic [16:0] cnt_nxt;
    logic [7:0]  lo_stage_q;
    logic [7:0]  lo_stage_nxt;
    logic [15:0] pend_div_q;
    logic [15:0] pend_div_nxt;
    logic        pend_q;
    logic        pend_nxt;
    logic [15:0] div_nxt;

    logic        lo_wr;
    logic        hi_wr;
    logic        wrap;
    logic        commit;

    logic [16:0] period_cur;
    logic [16:0] last_cur;
    logic [16:0] period_nxt;
    logic [16:0] last_nxt;
    logic [16:0] half_nxt;

    logic        uart_clk_nxt;
    logic        baud_tick_nxt;

    // Decode register writes and the period arithmetic for the divisor in use.
    always_comb begin
        lo_wr      = wr_en & ~wr_addr;
        hi_wr      = wr_en & wr_addr;
        period_cur = {1'b0, div_active} + 17'd16;
        last_cur   = period_cur - 17'd1;
        wrap       = (cnt_q == last_cur);
    end

    // Next-state logic: decides when a staged divisor commits and which state
    // the generator moves to.
    always_comb begin
        commit    = 1'b0;
        state_nxt = IDLE;

        case (state_q)
            IDLE: begin
                // Counter is parked at 0 here, so with en high the wrap
                // cannot occur this cycle; only a disabled generator commits.
                commit = pend_q & ~en;
            end
            RUN: begin
                commit = 1'b0;
            end
            PEND: begin
                commit = ~en | wrap;
            end
            default: begin
                commit = pend_q & ~en;
            end
        endcase

        if (hi_wr) begin
            pend_nxt = 1'b1;
        end else if (commit) begin
            pend_nxt = 1'b0;
        end else begin
            pend_nxt = pend_q;
        end

        if (!en) begin
            state_nxt = IDLE;
        end else if (pend_nxt) begin
            state_nxt = PEND;
        end else begin
            state_nxt = RUN;
        end
    end

    // Datapath next values: staging registers, divisor, counter and the
    // output shape computed from the post-edge counter so outputs line up
    // with cnt after the same edge.
    always_comb begin
        lo_stage_nxt = lo_wr ? wr_data : lo_stage_q;
        pend_div_nxt = hi_wr ? {wr_data, lo_stage_q} : pend_div_q;
        div_nxt      = commit ? pend_div_q : div_active;

        if (!en) begin
            cnt_nxt = 17'd0;
        end else if (wrap) begin
            cnt_nxt = 17'd0;
        end else begin
            cnt_nxt = cnt_q + 17'd1;
        end

        period_nxt    = {1'b0, div_nxt} + 17'd16;
        last_nxt      = period_nxt - 17'd1;
        half_nxt      = (period_nxt + 17'd1) >> 1;

        uart_clk_nxt  = en & (cnt_nxt >= half_nxt);
        baud_tick_nxt = en & (cnt_nxt == last_nxt);
    end

    // State register for the generator FSM.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Registered datapath and outputs; reset discards any staged divisor.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            cnt_q      <= 17'd0;
            lo_stage_q <= RST_DIV[7:0];
            pend_div_q <= RST_DIV;
            pend_q     <= 1'b0;
            div_active <= RST_DIV;
            uart_clk   <= 1'b0;
            baud_tick  <= 1'b0;
        end else begin
            cnt_q      <= cnt_nxt;
            lo_stage_q <= lo_stage_nxt;
            pend_div_q <= pend_div_nxt;
            pend_q     <= pend_nxt;
            div_active <= div_nxt;
            uart_clk   <= uart_clk_nxt;
            baud_tick  <= baud_tick_nxt;
        end
    end

    assign cfg_busy = pend_q;

`ifdef BRG_CTRL_DONE_EN
    // One-cycle pulse following every commit edge.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            cfg_done <= 1'b0;
        end else begin
            cfg_done <= commit;
        end
    end
`endif

endmodule

// File: tb/tb_brg_ctrl.sv
// tb_brg_ctrl: scoreboard bench for brg_ctrl. Stimulus pushes the expected
// uart_clk rise cycles, baud_tick cycles (with the divisor in use) and commit
// pulses into queues; a monitor pops and compares whenever the DUT shows them.
// Cycle numbers count rising edges since time zero; sampling is on the
// falling edge.

module tb_brg_ctrl;

    logic        sys_clk = 1'b0;
    logic        rst     = 1'b1;
    logic        en      = 1'b0;
    logic        wr_en   = 1'b0;
    logic        wr_addr = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic [15:0] div_active;
    logic        cfg_busy;
    logic        uart_clk;
    logic        baud_tick;
`ifdef BRG_CTRL_DONE_EN
    logic        cfg_done;
`endif

    int cyc          = 0;
    int tests_run    = 0;
    int tests_failed = 0;
    int base         = 0;

    typedef struct {
        int          at;
        logic [15:0] div;
    } tick_exp_t;

    tick_exp_t tick_q[$];
    int        rise_q[$];
    int        done_q[$];

    brg_ctrl #(.RST_DIV(16'h02F0)) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .en         (en),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .div_active (div_active),
        .cfg_busy   (cfg_busy),
        .uart_clk   (uart_clk),
        .baud_tick  (baud_tick)
`ifdef BRG_CTRL_DONE_EN
        ,
        .cfg_done   (cfg_done)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h",
                     name, cyc, actual, expected);
        end
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) @(negedge sys_clk);
        if (cyc != target) begin
            tests_failed++;
            $display("[TB] FAIL schedule: at cycle %0d, wanted %0d", cyc, target);
        end
    endtask

    task automatic applyStimulus(input int at, input logic addr, input logic [7:0] data);
        waitUntil(at);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        @(negedge sys_clk);
        wr_en   = 1'b0;
    endtask

    task automatic expectPeriod(input int start, input int period, input logic [15:0] div);
        tick_exp_t t;
        rise_q.push_back(start + (period + 1) / 2);
        t.at  = start + period - 1;
        t.div = div;
        tick_q.push_back(t);
    endtask

    task automatic runMonitor();
        logic      prev_clk;
        tick_exp_t t;
        prev_clk = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (uart_clk === 1'b1 && prev_clk === 1'b0) begin
                if (rise_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL unexpected_rise: uart_clk rose at cycle %0d, none expected", cyc);
                end else begin
                    checkOutput("rise_cycle", cyc, rise_q.pop_front());
                end
            end
            prev_clk = uart_clk;
            if (baud_tick === 1'b1) begin
                if (tick_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL unexpected_tick: baud_tick at cycle %0d, none expected", cyc);
                end else begin
                    t = tick_q.pop_front();
                    checkOutput("tick_cycle", cyc, t.at);
                    checkOutput("tick_div", {16'h0, div_active}, {16'h0, t.div});
                    checkOutput("tick_clk_high", {31'h0, uart_clk}, 32'd1);
                end
            end
`ifdef BRG_CTRL_DONE_EN
            if (cfg_done === 1'b1) begin
                if (done_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL unexpected_done: cfg_done at cycle %0d, none expected", cyc);
                end else begin
                    checkOutput("done_cycle", cyc, done_q.pop_front());
                end
            end
`endif
        end
    endtask

    initial begin
        fork
            runMonitor();
        join_none

        // Reset values
        repeat (3) @(negedge sys_clk);
        checkOutput("rst_div", {16'h0, div_active}, 32'h02F0);
        checkOutput("rst_busy", {31'h0, cfg_busy}, 32'd0);
        checkOutput("rst_uart_clk", {31'h0, uart_clk}, 32'd0);
        checkOutput("rst_tick", {31'h0, baud_tick}, 32'd0);
`ifdef BRG_CTRL_DONE_EN
        checkOutput("rst_done", {31'h0, cfg_done}, 32'd0);
`endif
        rst = 1'b0;
        @(negedge sys_clk);
        base = cyc;
        en   = 1'b1;

        // Full expected schedule of rises, ticks and commit pulses
        expectPeriod(base + 0,     768,   16'h02F0);
        expectPeriod(base + 768,   768,   16'h02F0);
        expectPeriod(base + 1536,  768,   16'h02F0);
        expectPeriod(base + 2304,  17,    16'h0001);
        expectPeriod(base + 2321,  17,    16'h0001);
        expectPeriod(base + 2338,  17,    16'h0001);
        expectPeriod(base + 2355,  17,    16'h0001);
        expectPeriod(base + 2372,  272,   16'h0100);
        expectPeriod(base + 2644,  272,   16'h0100);
        expectPeriod(base + 2916,  65551, 16'hFFFF);
        expectPeriod(base + 68467, 32,    16'h0010);
        expectPeriod(base + 68499, 32,    16'h0010);
        rise_q.push_back(base + 68547);
        expectPeriod(base + 68560, 272,   16'h0100);
        expectPeriod(base + 68846, 768,   16'h02F0);
        done_q.push_back(base + 2304);
        done_q.push_back(base + 2372);
        done_q.push_back(base + 2916);
        done_q.push_back(base + 68467);
        done_q.push_back(base + 68556);

        // Divisor lo=01 hi=00 mid-period: pending until the 768 period ends
        applyStimulus(base + 1600, 1'b0, 8'h01);
        applyStimulus(base + 1601, 1'b1, 8'h00);
        checkOutput("busy_after_hi", {31'h0, cfg_busy}, 32'd1);
        waitUntil(base + 2303);
        checkOutput("busy_last_cycle", {31'h0, cfg_busy}, 32'd1);
        checkOutput("div_before_commit", {16'h0, div_active}, 32'h02F0);
        waitUntil(base + 2304);
        checkOutput("busy_after_commit", {31'h0, cfg_busy}, 32'd0);
        checkOutput("div_after_commit", {16'h0, div_active}, 32'h0001);

        // Two high-byte writes in one period: last wins, single commit
        applyStimulus(base + 2357, 1'b0, 8'h00);
        applyStimulus(base + 2358, 1'b1, 8'h00);
        applyStimulus(base + 2360, 1'b1, 8'h01);
        waitUntil(base + 2371);
        checkOutput("busy_double_hi", {31'h0, cfg_busy}, 32'd1);
        checkOutput("div_double_hi_old", {16'h0, div_active}, 32'h0001);
        waitUntil(base + 2372);
        checkOutput("busy_double_hi_done", {31'h0, cfg_busy}, 32'd0);
        checkOutput("div_double_hi_new", {16'h0, div_active}, 32'h0100);

        // Divisor FFFF, then a high write landing in the commit cycle
        applyStimulus(base + 2650, 1'b0, 8'hFF);
        applyStimulus(base + 2651, 1'b1, 8'hFF);
        applyStimulus(base + 2914, 1'b0, 8'h10);
        applyStimulus(base + 2915, 1'b1, 8'h00);
        checkOutput("busy_hi_in_commit", {31'h0, cfg_busy}, 32'd1);
        checkOutput("div_ffff", {16'h0, div_active}, 32'hFFFF);
        waitUntil(base + 68466);
        checkOutput("busy_ffff_end", {31'h0, cfg_busy}, 32'd1);
        checkOutput("div_ffff_end", {16'h0, div_active}, 32'hFFFF);
        // Low-byte write in the commit cycle must not disturb that commit
        applyStimulus(base + 68466, 1'b0, 8'h77);
        checkOutput("busy_0010", {31'h0, cfg_busy}, 32'd0);
        checkOutput("div_0010", {16'h0, div_active}, 32'h0010);

        // Disable mid high phase: truncated period, clock low next cycle
        waitUntil(base + 68551);
        checkOutput("clk_high_before_off", {31'h0, uart_clk}, 32'd1);
        en = 1'b0;
        waitUntil(base + 68552);
        checkOutput("clk_low_after_off", {31'h0, uart_clk}, 32'd0);

        // Pending write while disabled commits on the next edge
        applyStimulus(base + 68553, 1'b0, 8'h00);
        applyStimulus(base + 68554, 1'b1, 8'h01);
        checkOutput("busy_idle_pend", {31'h0, cfg_busy}, 32'd1);
        checkOutput("div_idle_pend", {16'h0, div_active}, 32'h0010);
        checkOutput("clk_idle_pend", {31'h0, uart_clk}, 32'd0);
        waitUntil(base + 68556);
        checkOutput("busy_idle_commit", {31'h0, cfg_busy}, 32'd0);
        checkOutput("div_idle_commit", {16'h0, div_active}, 32'h0100);
        checkOutput("clk_idle_commit", {31'h0, uart_clk}, 32'd0);
        waitUntil(base + 68560);
        en = 1'b1;

        // Reset while a write is pending and mid-period
        applyStimulus(base + 68840, 1'b0, 8'h05);
        applyStimulus(base + 68841, 1'b1, 8'h00);
        checkOutput("busy_before_rst", {31'h0, cfg_busy}, 32'd1);
        waitUntil(base + 68845);
        rst = 1'b1;
        waitUntil(base + 68846);
        checkOutput("rst_mid_div", {16'h0, div_active}, 32'h02F0);
        checkOutput("rst_mid_busy", {31'h0, cfg_busy}, 32'd0);
        checkOutput("rst_mid_clk", {31'h0, uart_clk}, 32'd0);
        checkOutput("rst_mid_tick", {31'h0, baud_tick}, 32'd0);
        rst = 1'b0;

        waitUntil(base + 69614);
        en = 1'b0;
        waitUntil(base + 69620);

        checkOutput("rises_left", rise_q.size(), 32'd0);
        checkOutput("ticks_left", tick_q.size(), 32'd0);
`ifdef BRG_CTRL_DONE_EN
        checkOutput("dones_left", done_q.size(), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
